cook_timer: RTL and testbench
=============================

Name: cook_timer

Overview:
- Countdown cook timer, directly upstream of the magnetron control block; drives that block's timer_done input.
- Accepts keypad digits into an MM:SS BCD register.
- Counts down one second per prescaled tick while the magnetron is on.
- Flags completion so the magnetron control drops mag_on.

Parameters:
- TICK_DIV, 50000000: clk cycles per 1-second tick (50 MHz board); benches use 4.
- PW, 26: prescaler width; must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- clearn  in  1  synchronous active-low clear (same signal as the magnetron control clearn).
- mag_on  in  1  count enable, fed back from the magnetron control output.
- key_valid  in  1  one-cycle strobe, key_digit is valid.
- key_digit  in  4  BCD digit 0-9 from keypad decoder.
- min_tens  out  4  BCD minutes tens.
- min_ones  out  4  BCD minutes ones.
- sec_tens  out  4  BCD seconds tens.
- sec_ones  out  4  BCD seconds ones.
- timer_done  out  1  registered level; count expired.
- running  out  1  high in RUN state.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rstn).
- rstn=0 forces:
  - all four digits = 0
  - timer_done = 0
  - running = 0
  - prescaler = 0
  - state = IDLE
- States (all transitions on the rising clk edge):
  - IDLE: count == 0000, timer_done = 0.
  - SET: count != 0, stopped.
  - RUN: counting.
  - DONE: expired.
- Priority, highest first:
  - rstn
  - clearn = 0: digits = 0, timer_done = 0, prescaler = 0, state = IDLE. Takes effect on the next edge, in any state.
  - the state actions below.
- Key entry, accepted only when mag_on = 0 and key_valid = 1 and key_digit <= 9:
  - Shift left: min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= key_digit.
  - Old min_tens is discarded.
  - Result: SET if the new count != 0, else IDLE.
  - In DONE, a key also clears timer_done before shifting; the shift starts from 0000.
  - Digits 10-15 are ignored: no change, no state change.
  - Keys while mag_on = 1 are ignored.
- IDLE/SET with mag_on = 1:
  - From SET: go to RUN, prescaler = 0.
  - From IDLE (nothing loaded): go to DONE, timer_done = 1 on that edge.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler == TICK_DIV-1: prescaler = 0 and the count decrements by one second on the same edge.
  - First decrement therefore lands TICK_DIV edges after entering RUN.
- RUN with mag_on = 0 (stop/door open): go to SET, prescaler = 0. The partial second is lost and the digits are held.
- BCD decrement:
  - sec_ones 0 -> 9 with borrow; else -1.
  - sec_tens 0 -> 5 with borrow; else -1. Entered values 6-9 simply count down, so "90" counts 90 s.
  - min_ones 0 -> 9 with borrow.
  - min_tens -1.
  - Never applied at 0000.
- Expiry: the decrement that produces 0000 sets timer_done = 1 and state = DONE on the same edge; running = 0 from that edge.
- DONE:
  - Digits held at 0000; timer_done held high regardless of mag_on.
  - Exit only via clearn, rstn or a valid key (with mag_on = 0).
- running = 1 exactly in RUN. All outputs are registered; no combinational paths from input to output.
- Maximum count is 99:99; wrap-around never occurs.

Test Plan (TICK_DIV = 4):
1. Keys 1, 3, 0 with mag_on = 0 -> digits 0,1,3,0 (01:30), state SET, timer_done = 0. Key 0xA next -> digits unchanged.
2. From 01:30, mag_on = 1 -> running = 1 next edge; 01:29 after 4 edges. From 01:00, one tick -> 00:59. From 00:10, one tick -> 00:09.
3. Load 00:02, mag_on = 1 -> 00:01 after 4 edges, 00:00 after 8 edges with timer_done = 1 and running = 0 on the same edge. mag_on toggled afterwards -> timer_done stays 1.
4. RUN at 00:45, mag_on = 0 after 2 edges -> state SET, digits 00:45. mag_on = 1 again -> 00:44 four edges later. A key pulsed during RUN -> digits unchanged.
5. Count 0000 (IDLE), mag_on = 1 -> timer_done = 1 next edge. clearn = 0 for one cycle -> timer_done = 0, digits 0. Key 5 in DONE -> timer_done = 0, 00:05.
6. rstn asserted mid-RUN at 12:34 between edges -> all outputs 0 immediately, without waiting for clk. Release -> state IDLE.

Source files
------------

// File: rtl/cook_timer.sv
// Countdown cook timer: keypad-loaded MM:SS BCD count, one-second decrements while
// the magnetron is on, and a registered timer_done level for the magnetron control.
module cook_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int PW       = 26
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clearn,
    input  logic       mag_on,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       running
);

    typedef enum logic [1:0] {IDLE, SET, RUN, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
    logic          dec_zero;
    logic          key_ok;
    logic          tick;

    assign key_ok = key_valid && (key_digit <= 4'd9);
    assign tick   = (presc == PW'(TICK_DIV - 1));

    // One-second BCD decrement; seconds tens borrows to 5, so entered 6-9 just count down.
    always_comb begin
        dec_mt = min_tens;
        dec_mo = min_ones;
        dec_st = sec_tens;
        dec_so = sec_ones;
        if (sec_ones != 4'd0) begin
            dec_so = sec_ones - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_st = sec_tens - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (min_ones != 4'd0) begin
                    dec_mo = min_ones - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = min_tens - 4'd1;
                end
            end
        end
    end

    assign dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            presc      <= '0;
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            timer_done <= 1'b0;
            running    <= 1'b0;
        end else if (!clearn) begin
            state      <= IDLE;
            presc      <= '0;
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            timer_done <= 1'b0;
            running    <= 1'b0;
        end else begin
            case (state)
                IDLE, SET: begin
                    if (mag_on) begin
                        presc <= '0;
                        if (state == SET) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end else begin
                            state      <= DONE;
                            timer_done <= 1'b1;
                        end
                    end else if (key_ok) begin
                        min_tens <= min_ones;
                        min_ones <= sec_tens;
                        sec_tens <= sec_ones;
                        sec_ones <= key_digit;
                        state    <= ({min_ones, sec_tens, sec_ones, key_digit} != 16'h0000)
                                    ? SET : IDLE;
                    end
                end
                RUN: begin
                    if (!mag_on) begin
                        // Stop drops the partial second; digits are held as-is.
                        state   <= SET;
                        presc   <= '0;
                        running <= 1'b0;
                    end else if (tick) begin
                        presc    <= '0;
                        min_tens <= dec_mt;
                        min_ones <= dec_mo;
                        sec_tens <= dec_st;
                        sec_ones <= dec_so;
                        if (dec_zero) begin
                            state      <= DONE;
                            timer_done <= 1'b1;
                            running    <= 1'b0;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                DONE: begin
                    // A key restarts entry from 0000, so only the new digit survives.
                    if (!mag_on && key_ok) begin
                        timer_done <= 1'b0;
                        min_tens   <= 4'd0;
                        min_ones   <= 4'd0;
                        sec_tens   <= 4'd0;
                        sec_ones   <= key_digit;
                        state      <= (key_digit != 4'd0) ? SET : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with TICK_DIV = 4: inputs change on the falling edge,
// outputs are checked on the following falling edge.
module tb_cook_timer;

    logic       clk = 1'b0;
    logic       rstn, clearn, mag_on, key_valid;
    logic [3:0] key_digit;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, running;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;

    assign cnt = {min_tens, min_ones, sec_tens, sec_ones};

    cook_timer #(.TICK_DIV(4), .PW(3)) dut (
        .clk(clk), .rstn(rstn), .clearn(clearn), .mag_on(mag_on),
        .key_valid(key_valid), .key_digit(key_digit),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .timer_done(timer_done), .running(running)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    // Stop, then shift in all four digits so the old count is fully replaced.
    task automatic load4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        mag_on = 1'b0;
        step(1);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic test_reset;
        rstn = 1'b0; clearn = 1'b1; mag_on = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        #12;
        checks++;
        if (cnt !== 16'h0000 || timer_done !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset: cnt=%h done=%b run=%b, want 0000 0 0", cnt, timer_done, running);
        end
        @(negedge clk);
        rstn = 1'b1;
        step(1);
    endtask

    task automatic test_key_entry;
        key(4'd1); key(4'd3); key(4'd0);
        checks++;
        if (cnt !== 16'h0130 || timer_done !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL key_entry: cnt=%h done=%b run=%b, want 0130 0 0", cnt, timer_done, running);
        end
        key(4'hA);
        checks++;
        if (cnt !== 16'h0130) begin
            errors++;
            $display("FAIL key_invalid: cnt=%h, want 0130", cnt);
        end
    endtask

    task automatic test_countdown;
        mag_on = 1'b1;
        step(1);
        checks++;
        if (running !== 1'b1 || cnt !== 16'h0130) begin
            errors++;
            $display("FAIL run_enter: run=%b cnt=%h, want 1 0130", running, cnt);
        end
        step(3);
        checks++;
        if (cnt !== 16'h0130) begin
            errors++;
            $display("FAIL pre_tick: cnt=%h, want 0130", cnt);
        end
        step(1);
        checks++;
        if (cnt !== 16'h0129) begin
            errors++;
            $display("FAIL first_tick: cnt=%h, want 0129", cnt);
        end
    endtask

    task automatic test_borrow;
        load4(4'd0, 4'd1, 4'd0, 4'd0);
        mag_on = 1'b1;
        step(5);
        checks++;
        if (cnt !== 16'h0059) begin
            errors++;
            $display("FAIL borrow_min: cnt=%h, want 0059", cnt);
        end
        load4(4'd0, 4'd0, 4'd1, 4'd0);
        mag_on = 1'b1;
        step(5);
        checks++;
        if (cnt !== 16'h0009) begin
            errors++;
            $display("FAIL borrow_sec: cnt=%h, want 0009", cnt);
        end
        load4(4'd1, 4'd0, 4'd0, 4'd0);
        mag_on = 1'b1;
        step(5);
        checks++;
        if (cnt !== 16'h0959) begin
            errors++;
            $display("FAIL borrow_all: cnt=%h, want 0959", cnt);
        end
        load4(4'd0, 4'd0, 4'd9, 4'd0);
        mag_on = 1'b1;
        step(5);
        checks++;
        if (cnt !== 16'h0089) begin
            errors++;
            $display("FAIL sec_tens_90: cnt=%h, want 0089", cnt);
        end
    endtask

    task automatic test_expiry;
        load4(4'd0, 4'd0, 4'd0, 4'd2);
        mag_on = 1'b1;
        step(5);
        checks++;
        if (cnt !== 16'h0001 || timer_done !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL expiry_mid: cnt=%h done=%b run=%b, want 0001 0 1", cnt, timer_done, running);
        end
        step(3);
        checks++;
        if (cnt !== 16'h0001 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL expiry_early: cnt=%h done=%b, want 0001 0", cnt, timer_done);
        end
        step(1);
        checks++;
        if (cnt !== 16'h0000 || timer_done !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL expiry: cnt=%h done=%b run=%b, want 0000 1 0", cnt, timer_done, running);
        end
        mag_on = 1'b0;
        step(2);
        mag_on = 1'b1;
        step(2);
        checks++;
        if (cnt !== 16'h0000 || timer_done !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL done_hold: cnt=%h done=%b run=%b, want 0000 1 0", cnt, timer_done, running);
        end
    endtask

    task automatic test_pause;
        load4(4'd0, 4'd0, 4'd4, 4'd5);
        checks++;
        if (timer_done !== 1'b0 || cnt !== 16'h0045) begin
            errors++;
            $display("FAIL done_key_load: cnt=%h done=%b, want 0045 0", cnt, timer_done);
        end
        mag_on = 1'b1;
        step(3);
        mag_on = 1'b0;
        step(1);
        checks++;
        if (running !== 1'b0 || cnt !== 16'h0045) begin
            errors++;
            $display("FAIL pause: run=%b cnt=%h, want 0 0045", running, cnt);
        end
        mag_on = 1'b1;
        step(1);
        key(4'd7);
        checks++;
        if (running !== 1'b1 || cnt !== 16'h0045) begin
            errors++;
            $display("FAIL run_key: run=%b cnt=%h, want 1 0045", running, cnt);
        end
        step(2);
        checks++;
        if (cnt !== 16'h0045) begin
            errors++;
            $display("FAIL resume_early: cnt=%h, want 0045", cnt);
        end
        step(1);
        checks++;
        if (cnt !== 16'h0044) begin
            errors++;
            $display("FAIL resume_tick: cnt=%h, want 0044", cnt);
        end
    endtask

    task automatic test_clear_done;
        clearn = 1'b0;
        mag_on = 1'b0;
        step(1);
        clearn = 1'b1;
        checks++;
        if (cnt !== 16'h0000 || running !== 1'b0 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_run: cnt=%h run=%b done=%b, want 0000 0 0", cnt, running, timer_done);
        end
        mag_on = 1'b1;
        step(1);
        checks++;
        if (timer_done !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL idle_start: done=%b run=%b, want 1 0", timer_done, running);
        end
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        checks++;
        if (timer_done !== 1'b0 || cnt !== 16'h0000) begin
            errors++;
            $display("FAIL clear_done: done=%b cnt=%h, want 0 0000", timer_done, cnt);
        end
        step(1);
        mag_on = 1'b0;
        step(1);
        checks++;
        if (timer_done !== 1'b1) begin
            errors++;
            $display("FAIL done_again: done=%b, want 1", timer_done);
        end
        key(4'd5);
        checks++;
        if (timer_done !== 1'b0 || cnt !== 16'h0005 || running !== 1'b0) begin
            errors++;
            $display("FAIL done_key: done=%b cnt=%h run=%b, want 0 0005 0", timer_done, cnt, running);
        end
    endtask

    task automatic test_async_reset;
        load4(4'd1, 4'd2, 4'd3, 4'd4);
        mag_on = 1'b1;
        step(2);
        checks++;
        if (running !== 1'b1 || cnt !== 16'h1234) begin
            errors++;
            $display("FAIL pre_reset: run=%b cnt=%h, want 1 1234", running, cnt);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (cnt !== 16'h0000 || running !== 1'b0 || timer_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%h run=%b done=%b, want 0000 0 0", cnt, running, timer_done);
        end
        @(negedge clk);
        rstn = 1'b1;
        step(1);
        step(1);
        checks++;
        if (cnt !== 16'h0000 || running !== 1'b0 || timer_done !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: cnt=%h run=%b done=%b, want 0000 0 1", cnt, running, timer_done);
        end
    endtask

    initial begin
        test_reset();
        test_key_entry();
        test_countdown();
        test_borrow();
        test_expiry();
        test_pause();
        test_clear_done();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
